// File: rtl/uart_tx_buffered.sv
// Byte FIFO feeding an 8N1 UART serializer; one bit lasts 16 en_16_x_baud strobes.
// The FIFO pops only when the serializer loads a byte, so back-to-back frames have no idle gap.
module uart_tx_buffered #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en_16_x_baud,
    input  logic [7:0] data_in,
    input  logic       write_buffer,
    output logic       serial_out,
    output logic       buffer_full,
    output logic       buffer_half_full,
    output logic       buffer_empty,
    output logic       tx_busy,
    output logic       overflow
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] HALF_CNT = (ADDR_W+1)'(DEPTH / 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state, state_next;
    logic [3:0]          tick, tick_next;
    logic [2:0]          bit_idx, bit_idx_next;
    logic [7:0]          shift, shift_next;
    logic                serial_next;
    logic                pop;

    logic [7:0]          mem [0:DEPTH-1];
    logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
    logic [ADDR_W:0]     count, count_next;
    logic                wr_ok;

    assign wr_ok      = write_buffer && !buffer_full;
    assign count_next = count + {{ADDR_W{1'b0}}, wr_ok} - {{ADDR_W{1'b0}}, pop};

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Flags are registered from the next count so they always agree with count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            buffer_empty     <= 1'b1;
            buffer_full      <= 1'b0;
            buffer_half_full <= 1'b0;
            overflow         <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            if (write_buffer && buffer_full) begin
                overflow <= 1'b1;
            end
            count            <= count_next;
            buffer_empty     <= (count_next == '0);
            buffer_full      <= (count_next == FULL_CNT);
            buffer_half_full <= (count_next >= HALF_CNT);
        end
    end

    always_comb begin
        state_next   = state;
        tick_next    = tick;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                tick_next = '0;
                if (en_16_x_baud && !buffer_empty) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    state_next = START;
                end
            end
            START: begin
                if (en_16_x_baud) begin
                    tick_next = tick + 4'd1;
                    if (tick == 4'd15) begin
                        bit_idx_next = '0;
                        state_next   = DATA;
                    end
                end
            end
            DATA: begin
                if (en_16_x_baud) begin
                    tick_next = tick + 4'd1;
                    if (tick == 4'd15) begin
                        shift_next   = shift >> 1;
                        bit_idx_next = bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state_next = STOP;
                        end
                    end
                end
            end
            STOP: begin
                if (en_16_x_baud) begin
                    tick_next = tick + 4'd1;
                    if (tick == 4'd15) begin
                        if (!buffer_empty) begin
                            pop        = 1'b1;
                            shift_next = mem[rd_ptr];
                            state_next = START;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // The line level is decoded from the next state, so the pin itself is a flop.
        case (state_next)
            START:   serial_next = 1'b0;
            DATA:    serial_next = shift_next[0];
            default: serial_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tick       <= '0;
            bit_idx    <= '0;
            serial_out <= 1'b1;
            tx_busy    <= 1'b0;
        end else begin
            state      <= state_next;
            tick       <= tick_next;
            bit_idx    <= bit_idx_next;
            serial_out <= serial_next;
            tx_busy    <= (state_next != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        shift <= shift_next;
    end

endmodule
